// File: rtl/alu_mdu_pkg.sv
// Shared definitions for the ALU/MDU: ALUFun encodings, MDU operation codes
// and the control FSM state type.
package alu_pkg;

  localparam logic [5:0] ADD   = 6'b000000;
  localparam logic [5:0] SUB   = 6'b000001;
  localparam logic [5:0] AND   = 6'b011000;
  localparam logic [5:0] OR    = 6'b011110;
  localparam logic [5:0] XOR   = 6'b010110;
  localparam logic [5:0] NOR   = 6'b010001;
  localparam logic [5:0] PASSA = 6'b011010;
  localparam logic [5:0] SLL   = 6'b100000;
  localparam logic [5:0] SRL   = 6'b100001;
  localparam logic [5:0] SRA   = 6'b100011;
  localparam logic [5:0] EQ    = 6'b110011;
  localparam logic [5:0] NEQ   = 6'b110001;
  localparam logic [5:0] LT    = 6'b110101;
  localparam logic [5:0] LEZ   = 6'b111101;
  localparam logic [5:0] GEZ   = 6'b111001;
  localparam logic [5:0] GTZ   = 6'b111111;

  localparam logic [1:0] MDU_ALU  = 2'b00;
  localparam logic [1:0] MDU_MULT = 2'b01;
  localparam logic [1:0] MDU_DIV  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mdu_core.sv
// Combinational WIDTH-bit ALU decoding the 6-bit ALUFun field, producing the
// result together with zero, negative and signed-overflow flags.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [5:0]       i_fun,
  input  logic             i_sign,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_z,
  output logic             o_zero,
  output logic             o_neg,
  output logic             o_ovf
);
  localparam int SW = $clog2(WIDTH);

  logic [WIDTH-1:0] w_bOp;
  logic [WIDTH-1:0] w_sum;
  logic [SW-1:0]    w_shamt;
  logic             w_lt;
  logic             w_aZero;
  logic             w_aNeg;
  logic             w_cmp;

  // Subtraction is a + ~b + 1, so a single overflow rule covers add and sub.
  assign w_bOp   = i_fun[0] ? ~i_b : i_b;
  assign w_sum   = i_a + w_bOp + {{(WIDTH-1){1'b0}}, i_fun[0]};
  assign w_shamt = i_a[SW-1:0];
  assign w_lt    = i_sign ? ($signed(i_a) < $signed(i_b)) : (i_a < i_b);
  assign w_aZero = (i_a == '0);
  assign w_aNeg  = i_a[WIDTH-1];

  always_comb begin
    o_z   = '0;
    o_ovf = 1'b0;
    w_cmp = 1'b0;
    case (i_fun[5:4])
      2'b00: begin
        o_z   = w_sum;
        o_ovf = (i_a[WIDTH-1] == w_bOp[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
      end
      2'b01: begin
        case (i_fun[3:0])
          AND[3:0]:   o_z = i_a & i_b;
          OR[3:0]:    o_z = i_a | i_b;
          XOR[3:0]:   o_z = i_a ^ i_b;
          NOR[3:0]:   o_z = ~(i_a | i_b);
          PASSA[3:0]: o_z = i_a;
          default:    o_z = '0;
        endcase
      end
      2'b10: begin
        case (i_fun[1:0])
          SLL[1:0]: o_z = i_b << w_shamt;
          SRL[1:0]: o_z = i_b >> w_shamt;
          SRA[1:0]: o_z = $signed(i_b) >>> w_shamt;
          default:  o_z = '0;
        endcase
      end
      default: begin
        // Zero-based compares look only at a as a signed value.
        case (i_fun[3:1])
          EQ[3:1]:  w_cmp = (i_a == i_b);
          NEQ[3:1]: w_cmp = (i_a != i_b);
          LT[3:1]:  w_cmp = w_lt;
          LEZ[3:1]: w_cmp = w_aNeg || w_aZero;
          GEZ[3:1]: w_cmp = !w_aNeg;
          GTZ[3:1]: w_cmp = !w_aNeg && !w_aZero;
          default:  w_cmp = 1'b0;
        endcase
        o_z = {{(WIDTH-1){1'b0}}, w_cmp};
      end
    endcase
  end

  assign o_zero = (o_z == '0);
  assign o_neg  = o_z[WIDTH-1];

endmodule

// File: rtl/alu_mdu.sv
// Handshaked ALU with registered results and an iterative shift-add multiplier /
// restoring divider producing HI/LO. Define ALU_MDU_DIV_EN to build the divider.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       alu_fun,
  input  logic [1:0]       mdu_op,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             err
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t r_state, w_next;

  logic [WIDTH-1:0]   r_z, r_hi, r_lo;
  logic               r_zero, r_neg, r_ovf, r_err;
  logic [WIDTH-1:0]   r_wHi, r_wLo, r_opnd;
  logic [CW-1:0]      r_cnt;
  logic               r_negQ;

  logic               w_accept, w_isMul, w_isDiv, w_mduReq, w_finErr;
  logic               w_aNeg, w_bNeg;
  logic [WIDTH-1:0]   w_aMag, w_bMag, w_addend;
  logic [WIDTH:0]     w_mulSum;
  logic [2*WIDTH-1:0] w_prod, w_prodFin;
  logic [WIDTH-1:0]   w_stepHi, w_stepLo, w_finHi, w_finLo;
  logic [WIDTH-1:0]   w_aluZ;
  logic               w_aluZero, w_aluNeg, w_aluOvf;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .i_fun  (alu_fun),
    .i_sign (sign),
    .i_a    (a),
    .i_b    (b),
    .o_z    (w_aluZ),
    .o_zero (w_aluZero),
    .o_neg  (w_aluNeg),
    .o_ovf  (w_aluOvf)
  );

  assign w_isMul  = (mdu_op == MDU_MULT);
  assign w_isDiv  = (mdu_op == MDU_DIV);
  assign w_accept = in_valid && in_ready;
  assign w_aNeg   = sign && a[WIDTH-1];
  assign w_bNeg   = sign && b[WIDTH-1];
  assign w_aMag   = w_aNeg ? -a : a;
  assign w_bMag   = w_bNeg ? -b : b;

  // One multiply step: conditionally add the multiplicand into HI, then shift {HI,LO} right.
  assign w_addend  = r_wLo[0] ? r_opnd : '0;
  assign w_mulSum  = {1'b0, r_wHi} + {1'b0, w_addend};
  assign w_prod    = {w_mulSum, r_wLo[WIDTH-1:1]};
  assign w_prodFin = r_negQ ? -w_prod : w_prod;

`ifdef ALU_MDU_DIV_EN
  logic           r_isDiv, r_negR, r_divZero;
  logic [WIDTH:0] w_shifted;
  logic           w_ge;
  logic [WIDTH-1:0] w_qStep, w_rStep;

  assign w_mduReq  = w_isMul || w_isDiv;
  // Remainder below the divisor always fits WIDTH bits, so the subtraction is done modulo 2^WIDTH.
  assign w_shifted = {r_wHi, r_wLo[WIDTH-1]};
  assign w_ge      = (w_shifted >= {1'b0, r_opnd});
  assign w_rStep   = w_ge ? (w_shifted[WIDTH-1:0] - r_opnd) : w_shifted[WIDTH-1:0];
  assign w_qStep   = {r_wLo[WIDTH-2:0], w_ge};
  assign w_finErr  = r_isDiv && r_divZero;
`else
  assign w_mduReq  = w_isMul;
  assign w_finErr  = 1'b0;
`endif

  always_comb begin
    w_stepHi = w_prod[2*WIDTH-1:WIDTH];
    w_stepLo = w_prod[WIDTH-1:0];
    w_finHi  = w_prodFin[2*WIDTH-1:WIDTH];
    w_finLo  = w_prodFin[WIDTH-1:0];
`ifdef ALU_MDU_DIV_EN
    if (r_isDiv) begin
      w_stepHi = w_rStep;
      w_stepLo = w_qStep;
      w_finHi  = r_negR ? -w_rStep : w_rStep;
      w_finLo  = r_divZero ? '1 : (r_negQ ? -w_qStep : w_qStep);
    end
`endif
  end

  // Next-state and ready: DONE can hand off straight into a new operation.
  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = w_mduReq ? BUSY : DONE;
      end
      BUSY: begin
        if (r_cnt == LAST) w_next = DONE;
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) w_next = in_valid ? (w_mduReq ? BUSY : DONE) : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_z    <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_zero <= 1'b0;
      r_neg  <= 1'b0;
      r_ovf  <= 1'b0;
      r_err  <= 1'b0;
      r_wHi  <= '0;
      r_wLo  <= '0;
      r_opnd <= '0;
      r_cnt  <= '0;
      r_negQ <= 1'b0;
`ifdef ALU_MDU_DIV_EN
      r_isDiv   <= 1'b0;
      r_negR    <= 1'b0;
      r_divZero <= 1'b0;
`endif
    end else if (w_accept) begin
      if (w_mduReq) begin
        r_wHi  <= '0;
        r_wLo  <= w_isMul ? w_bMag : w_aMag;
        r_opnd <= w_isMul ? w_aMag : w_bMag;
        r_cnt  <= '0;
        r_negQ <= w_aNeg ^ w_bNeg;
`ifdef ALU_MDU_DIV_EN
        r_isDiv   <= w_isDiv;
        r_negR    <= w_aNeg;
        r_divZero <= (b == '0);
`endif
      end
`ifndef ALU_MDU_DIV_EN
      else if (w_isDiv) begin
        r_z    <= '0;
        r_hi   <= '0;
        r_lo   <= '0;
        r_zero <= 1'b1;
        r_neg  <= 1'b0;
        r_ovf  <= 1'b0;
        r_err  <= 1'b1;
      end
`endif
      else begin
        r_z    <= w_aluZ;
        r_zero <= w_aluZero;
        r_neg  <= w_aluNeg;
        r_ovf  <= w_aluOvf;
        r_err  <= 1'b0;
      end
    end else if (r_state == BUSY) begin
      r_wHi <= w_stepHi;
      r_wLo <= w_stepLo;
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == LAST) begin
        r_hi   <= w_finHi;
        r_lo   <= w_finLo;
        r_z    <= w_finLo;
        r_zero <= (w_finLo == '0);
        r_neg  <= w_finLo[WIDTH-1];
        r_ovf  <= 1'b0;
        r_err  <= w_finErr;
      end
    end
  end

  assign out_valid = (r_state == DONE);
  assign z    = r_z;
  assign hi   = r_hi;
  assign lo   = r_lo;
  assign zero = r_zero;
  assign neg  = r_neg;
  assign ovf  = r_ovf;
  assign err  = r_err;

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: expected results are queued when a request is
// driven and popped when out_valid is seen.
module tb_alu_mdu;
  import alu_pkg::*;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] z;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic zero;
    logic neg;
    logic ovf;
    logic err;
  } res_t;

  typedef struct {
    logic [5:0]   f;
    logic         s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] z;
    logic         o;
  } aluVec_t;

  typedef struct {
    logic         s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         e;
  } mduVec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [5:0]   alu_fun = '0;
  logic [1:0]   mdu_op = '0;
  logic         sign = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] z, hi, lo;
  logic         zero, neg, ovf, err;

  res_t         expQ[$];
  int           latQ[$];
  logic [W-1:0] mHi = '0;
  logic [W-1:0] mLo = '0;
  int           checks = 0;
  int           failures = 0;

  alu_mdu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_fun   (alu_fun),
    .mdu_op    (mdu_op),
    .sign      (sign),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .hi        (hi),
    .lo        (lo),
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic res_t mk(input logic [W-1:0] ez, input logic eo, input logic ee);
    res_t r;
    r.z = ez;
    r.hi = mHi;
    r.lo = mLo;
    r.zero = (ez == '0);
    r.neg = ez[W-1];
    r.ovf = eo;
    r.err = ee;
    return r;
  endfunction

  function automatic res_t observe();
    return {z, hi, lo, zero, neg, ovf, err};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request, wait until accepted, then scramble operands to show they are not resampled.
  task automatic applyStimulus(input logic [5:0] f, input logic [1:0] op, input logic s,
                               input logic [W-1:0] av, input logic [W-1:0] bv);
    logic acc;
    logic taken;
    alu_fun = f;
    mdu_op = op;
    sign = s;
    a = av;
    b = bv;
    in_valid = 1'b1;
    taken = 1'b0;
    for (int k = 0; k < 100 && !taken; k++) begin
      acc = in_ready;
      tick();
      taken = acc;
    end
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    sign = ~s;
    checks++;
    if (!taken) begin
      failures++;
      $display("[TB] FAIL accept_timeout in_ready=%b required=1", in_ready);
    end
  endtask

  task automatic checkOutput(output int lat, output logic ok);
    lat = 0;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    ok = out_valid;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #3;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_hs out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    checks++;
    if (observe() !== res_t'(0)) begin
      failures++;
      $display("[TB] FAIL reset_outputs got=%h required=0", observe());
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alu_sweep();
    aluVec_t v [7];
    res_t e;
    int el, lat;
    logic ok;
    v = '{'{ADD,   1'b1, 32'd10, 32'd3, 32'd13,         1'b0},
          '{SUB,   1'b1, 32'd10, 32'd3, 32'd7,          1'b0},
          '{AND,   1'b1, 32'd10, 32'd3, 32'd2,          1'b0},
          '{OR,    1'b1, 32'd10, 32'd3, 32'd11,         1'b0},
          '{XOR,   1'b1, 32'd10, 32'd3, 32'd9,          1'b0},
          '{NOR,   1'b1, 32'd10, 32'd3, 32'hFFFFFFF4,   1'b0},
          '{PASSA, 1'b1, 32'd10, 32'd3, 32'd10,         1'b0}};
    for (int i = 0; i < 7; i++) begin
      expQ.push_back(mk(v[i].z, v[i].o, 1'b0));
      latQ.push_back(0);
      applyStimulus(v[i].f, MDU_ALU, v[i].s, v[i].a, v[i].b);
      checkOutput(lat, ok);
      e = expQ.pop_front();
      el = latQ.pop_front();
      checks++;
      if (!ok || observe() !== e) begin
        failures++;
        $display("[TB] FAIL alu_sweep[%0d] got=%h required=%h", i, observe(), e);
      end
      checks++;
      if (lat != el) begin
        failures++;
        $display("[TB] FAIL alu_sweep_latency[%0d] got=%0d required=%0d", i, lat + 1, el + 1);
      end
      tick();
    end
  endtask

  task automatic test_shift_compare();
    aluVec_t v [12];
    res_t e;
    int lat;
    logic ok;
    v = '{'{SRL,      1'b1, 32'd3,        32'hFFFFFFFF, 32'h1FFFFFFF, 1'b0},
          '{SRA,      1'b1, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0},
          '{SLL,      1'b0, 32'd4,        32'd1,        32'd16,       1'b0},
          '{LT,       1'b0, 32'd1,        32'hC0000000, 32'd1,        1'b0},
          '{LT,       1'b1, 32'd1,        32'hC0000000, 32'd0,        1'b0},
          '{GTZ,      1'b1, 32'd0,        32'd5,        32'd0,        1'b0},
          '{GEZ,      1'b1, 32'd0,        32'd5,        32'd1,        1'b0},
          '{LEZ,      1'b0, 32'hFFFFFFFF, 32'd5,        32'd1,        1'b0},
          '{EQ,       1'b0, 32'd5,        32'd5,        32'd1,        1'b0},
          '{NEQ,      1'b0, 32'd5,        32'd5,        32'd0,        1'b0},
          '{6'b110111, 1'b0, 32'd5,       32'd5,        32'd0,        1'b0},
          '{6'b010000, 1'b0, 32'd10,      32'd3,        32'd0,        1'b0}};
    for (int i = 0; i < 12; i++) begin
      expQ.push_back(mk(v[i].z, v[i].o, 1'b0));
      applyStimulus(v[i].f, MDU_ALU, v[i].s, v[i].a, v[i].b);
      checkOutput(lat, ok);
      e = expQ.pop_front();
      checks++;
      if (!ok || lat != 0 || observe() !== e) begin
        failures++;
        $display("[TB] FAIL shift_compare[%0d] got=%h lat=%0d required=%h lat=0", i, observe(), lat, e);
      end
      tick();
    end
  endtask

  task automatic test_overflow();
    aluVec_t v [4];
    res_t e;
    int lat;
    logic ok;
    v = '{'{ADD, 1'b1, 32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b1},
          '{SUB, 1'b1, 32'd5,        32'd5,        32'd0,        1'b0},
          '{SUB, 1'b0, 32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b1},
          '{ADD, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0}};
    for (int i = 0; i < 4; i++) begin
      expQ.push_back(mk(v[i].z, v[i].o, 1'b0));
      applyStimulus(v[i].f, MDU_ALU, v[i].s, v[i].a, v[i].b);
      checkOutput(lat, ok);
      e = expQ.pop_front();
      checks++;
      if (!ok || lat != 0 || observe() !== e) begin
        failures++;
        $display("[TB] FAIL overflow[%0d] got=%h required=%h", i, observe(), e);
      end
      tick();
    end
  endtask

  task automatic test_mult();
    mduVec_t v [3];
    res_t e;
    int el, lat;
    logic ok;
    v = '{'{1'b1, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0},
          '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0},
          '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0}};
    for (int i = 0; i < 3; i++) begin
      mHi = v[i].hi;
      mLo = v[i].lo;
      expQ.push_back(mk(v[i].lo, 1'b0, v[i].e));
      latQ.push_back(W);
      applyStimulus(6'h00, MDU_MULT, v[i].s, v[i].a, v[i].b);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL mult_busy in_ready=%b out_valid=%b required 0/0", in_ready, out_valid);
      end
      checkOutput(lat, ok);
      e = expQ.pop_front();
      el = latQ.pop_front();
      checks++;
      if (!ok || observe() !== e) begin
        failures++;
        $display("[TB] FAIL mult[%0d] got=%h required=%h", i, observe(), e);
      end
      checks++;
      if (lat != el) begin
        failures++;
        $display("[TB] FAIL mult_latency[%0d] got=%0d required=%0d", i, lat + 1, el + 1);
      end
      tick();
    end
  endtask

  task automatic test_div();
    res_t e;
    int el, lat;
    logic ok;
`ifdef ALU_MDU_DIV_EN
    mduVec_t v [6];
    v = '{'{1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0},
          '{1'b1, 32'hFFFFFF00, 32'd0,        32'hFFFFFF00, 32'hFFFFFFFF, 1'b1},
          '{1'b0, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 1'b1},
          '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0},
          '{1'b0, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0},
          '{1'b1, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0}};
    for (int i = 0; i < 6; i++) begin
      mHi = v[i].hi;
      mLo = v[i].lo;
      expQ.push_back(mk(v[i].lo, 1'b0, v[i].e));
      latQ.push_back(W);
      applyStimulus(6'h00, MDU_DIV, v[i].s, v[i].a, v[i].b);
`else
    for (int i = 0; i < 2; i++) begin
      mHi = '0;
      mLo = '0;
      expQ.push_back(mk('0, 1'b0, 1'b1));
      latQ.push_back(0);
      applyStimulus(ADD, MDU_DIV, i[0], 32'd9 + 32'(i), 32'd2);
`endif
      checkOutput(lat, ok);
      e = expQ.pop_front();
      el = latQ.pop_front();
      checks++;
      if (!ok || observe() !== e) begin
        failures++;
        $display("[TB] FAIL div[%0d] got=%h required=%h", i, observe(), e);
      end
      checks++;
      if (lat != el) begin
        failures++;
        $display("[TB] FAIL div_latency[%0d] got=%0d required=%0d", i, lat + 1, el + 1);
      end
      tick();
    end
  endtask

  task automatic test_handshake();
    res_t e;
    int lat;
    logic ok;
    out_ready = 1'b0;
    expQ.push_back(mk(32'd3, 1'b0, 1'b0));
    applyStimulus(ADD, MDU_ALU, 1'b0, 32'd1, 32'd2);
    checkOutput(lat, ok);
    e = expQ.pop_front();
    checks++;
    if (!ok || observe() !== e) begin
      failures++;
      $display("[TB] FAIL stall_first got=%h required=%h", observe(), e);
    end
    in_valid = 1'b1;
    alu_fun = SUB;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || observe() !== e) begin
        failures++;
        $display("[TB] FAIL stall_hold[%0d] got=%h v=%b r=%b required=%h v=1 r=0",
                 i, observe(), out_valid, in_ready, e);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL stall_release out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]   fset [5];
    logic [W-1:0] av, bv, ez;
    logic [W:0]   wide;
    logic         eo;
    int           k;
    res_t         e;
    fset = '{ADD, SUB, XOR, AND, OR};
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      k = i % 5;
      av = (i == 2) ? 32'h7FFFFFF0 : $urandom;
      bv = (i == 2) ? 32'h00000100 : $urandom;
      eo = 1'b0;
      case (k)
        0: begin
          ez = av + bv;
          wide = {av[W-1], av} + {bv[W-1], bv};
          eo = wide[W] != wide[W-1];
        end
        1: begin
          ez = av - bv;
          wide = {av[W-1], av} - {bv[W-1], bv};
          eo = wide[W] != wide[W-1];
        end
        2: ez = av ^ bv;
        3: ez = av & bv;
        default: ez = av | bv;
      endcase
      expQ.push_back(mk(ez, eo, 1'b0));
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("[TB] FAIL b2b_ready[%0d] got=%b required=1", i, in_ready);
      end
      alu_fun = fset[k];
      mdu_op = MDU_ALU;
      sign = 1'b1;
      a = av;
      b = bv;
      in_valid = 1'b1;
      tick();
      e = expQ.pop_front();
      checks++;
      if (out_valid !== 1'b1 || observe() !== e) begin
        failures++;
        $display("[TB] FAIL b2b[%0d] got=%h v=%b required=%h v=1", i, observe(), out_valid, e);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_drain out_valid=%b required=0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    res_t e;
    int lat;
    logic ok;
    applyStimulus(6'h00, MDU_MULT, 1'b0, 32'd5, 32'd6);
    repeat (10) tick();
    rst_n = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || observe() !== res_t'(0)) begin
      failures++;
      $display("[TB] FAIL reset_mid got=%h v=%b r=%b required=0 v=0 r=1", observe(), out_valid, in_ready);
    end
    rst_n = 1'b1;
    mHi = '0;
    mLo = '0;
    repeat (W + 4) tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_mid_ghost out_valid=%b required=0", out_valid);
    end
    expQ.push_back(mk(32'd5, 1'b0, 1'b0));
    applyStimulus(ADD, MDU_ALU, 1'b1, 32'd2, 32'd3);
    checkOutput(lat, ok);
    e = expQ.pop_front();
    checks++;
    if (!ok || lat != 0 || observe() !== e) begin
      failures++;
      $display("[TB] FAIL reset_mid_add got=%h required=%h", observe(), e);
    end
    tick();
  endtask

  initial begin
    $display("[TB] starting alu_mdu bench");
    test_reset();
    test_alu_sweep();
    test_mult();
    test_overflow();
    test_shift_compare();
    test_div();
    test_handshake();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
